// File: rtl/temp_sr_reader.sv
// Wishbone-attached reader for the temperature digitiser's serial result register.
// Generates shift_clk_o, deserialises sr_in MSB-first and exposes CTRL/STATUS/DATA.
module temp_sr_reader #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        sr_in,
    output logic        shift_clk_o,
    output logic        irq_o
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    state_e              state_q;
    logic [PH_W-1:0]     phase_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                overrun_q;
    logic                cont_q;
    logic                irq_en_q;
    logic                shift_clk_q;
    logic                ack_q;
    logic                sr_meta_q;
    logic                sr_s_q;

    logic                ack_d;
    logic [DATA_W-1:0]   shreg_d;
    logic [DATA_W:0]     shreg_ext;
    logic [31:0]         rd_data;
    logic [1:0]          sel;
    logic                busy;
    logic                ctrl_wr;
    logic                status_wr;
    logic                data_rd;
    logic                start_req;
    logic                last_phase;
    logic                unused_ok;

    assign sel        = wbs_adr_i[3:2];
    assign busy       = (state_q != IDLE);
    assign ack_d      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    // Register side effects take place in the ack cycle, while the master still holds the request.
    assign ctrl_wr    = ack_q &  wbs_we_i & (sel == 2'd0);
    assign status_wr  = ack_q &  wbs_we_i & (sel == 2'd1);
    assign data_rd    = ack_q & ~wbs_we_i & (sel == 2'd2);
    assign start_req  = ctrl_wr & wbs_dat_i[0];
    assign last_phase = (phase_q == PH_W'(CLK_DIV - 1));
    assign shreg_ext  = {shreg_q, sr_s_q};
    assign shreg_d    = shreg_ext[DATA_W-1:0];
    assign unused_ok  = ^{wbs_adr_i[1:0], wbs_dat_i[31:3]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (sel)
            2'd0:    rd_data[2:0] = {irq_en_q, cont_q, 1'b0};
            2'd1:    rd_data[2:0] = {overrun_q, valid_q, busy};
            2'd2:    rd_data[DATA_W-1:0] = data_q;
            default: rd_data = '0;
        endcase
    end

    assign wbs_dat_o   = ack_q ? rd_data : 32'd0;
    assign wbs_ack_o   = ack_q;
    assign shift_clk_o = shift_clk_q;
    assign irq_o       = valid_q & irq_en_q;

    // NOTE: sequential state uses non-blocking assignments only; where two assignments hit the
    // same flop in one cycle the later one wins, which gives the FSM's set priority over clears.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            cont_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            shift_clk_q <= 1'b0;
            ack_q       <= 1'b0;
            sr_meta_q   <= 1'b0;
            sr_s_q      <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            sr_meta_q <= sr_in;
            sr_s_q    <= sr_meta_q;

            if (ctrl_wr) begin
                cont_q   <= wbs_dat_i[1];
                irq_en_q <= wbs_dat_i[2];
            end
            if (data_rd) begin
                valid_q <= 1'b0;
            end
            if (status_wr && wbs_dat_i[2]) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    shift_clk_q <= 1'b0;
                    if (start_req) begin
                        state_q   <= LOW;
                        phase_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                LOW: begin
                    if (last_phase) begin
                        phase_q     <= '0;
                        shift_clk_q <= 1'b1;
                        state_q     <= HIGH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (last_phase) begin
                        phase_q     <= '0;
                        shreg_q     <= shreg_d;
                        bit_cnt_q   <= bit_cnt_q + 1'b1;
                        shift_clk_q <= 1'b0;
                        state_q     <= (bit_cnt_q < BIT_W'(DATA_W - 1)) ? LOW : DONE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                DONE: begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                    if (valid_q) begin
                        overrun_q <= 1'b1;
                    end
                    phase_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= cont_q ? LOW : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
